// File: rtl/tt_um_brs_logic_seq_if.sv
// Pin bundle for the conditional XOR/AND sequencer tile.
// The master side drives the input pins; the slave side is the tile itself.
interface tt_um_brs_logic_seq_if;
   logic [7:0] ui_in;
   logic [7:0] uio_in;
   logic       ena;
   logic [7:0] uo_out;
   logic [7:0] uio_out;
   logic [7:0] uio_oe;

   modport master (
      output ui_in, uio_in, ena,
      input  uo_out, uio_out, uio_oe
   );

   modport slave (
      input  ui_in, uio_in, ena,
      output uo_out, uio_out, uio_oe
   );
endinterface

// File: rtl/tt_um_brs_logic_seq.sv
// Sequencer for the conditional XOR/AND logic unit.
// A and B load over one shared bus; a start command runs acc <= f(acc, b_work)
// N times back-to-back, where f is XOR when acc[7]=0 and AND when acc[7]=1.
// Control pins are level inputs; only their rising edges are acted on.
module tt_um_brs_logic_seq #(
   parameter int ROT_B = 1,
   parameter int CNT_W = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   tt_um_brs_logic_seq_if.slave  bus
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

   // Mode follows the accumulator MSB of the current iteration.
   function automatic logic [7:0] logic_unit(input logic [7:0] acc, input logic [7:0] b);
      return acc[7] ? (acc & b) : (acc ^ b);
   endfunction

   function automatic logic [7:0] rotl1(input logic [7:0] v);
      return {v[6:0], v[7]};
   endfunction

   state_t           state_r, state_n;
   logic [7:0]       a_r, a_n;
   logic [7:0]       b_r, b_n;
   logic [7:0]       b_work_r, b_work_n;
   logic [7:0]       acc_r, acc_n;
   logic [CNT_W-1:0] cnt_r, cnt_n;
   logic             busy_r, busy_n;
   logic             done_r, done_n;
   logic             last_and_r, last_and_n;
   logic [3:0]       prev_ctl_r;
   logic [3:0]       ev_s;
   logic             unused_s;

   // Rising edges of ld_a, ld_b, start, clr.
   assign ev_s     = bus.uio_in[3:0] & ~prev_ctl_r;
   assign unused_s = ^{bus.ena, bus.uio_in[7:4]};

   // Next-state and datapath: clr beats start beats ld_a beats ld_b; only one acts.
   always_comb begin
      state_n    = state_r;
      a_n        = a_r;
      b_n        = b_r;
      b_work_n   = b_work_r;
      acc_n      = acc_r;
      cnt_n      = cnt_r;
      busy_n     = busy_r;
      done_n     = done_r;
      last_and_n = last_and_r;
      if (ev_s[3]) begin
         // Operand registers survive a clear.
         state_n    = ST_IDLE;
         acc_n      = 8'h00;
         cnt_n      = CNT_ZERO;
         busy_n     = 1'b0;
         done_n     = 1'b0;
         last_and_n = 1'b0;
      end else begin
         case (state_r)
            ST_IDLE, ST_DONE: begin
               if (ev_s[2]) begin
                  acc_n    = a_r;
                  b_work_n = b_r;
                  cnt_n    = bus.ui_in[CNT_W-1:0];
                  if (bus.ui_in[CNT_W-1:0] == CNT_ZERO) begin
                     // Zero iterations: result is A, reported one clock after start.
                     state_n = ST_DONE;
                     busy_n  = 1'b0;
                     done_n  = 1'b1;
                  end else begin
                     state_n = ST_RUN;
                     busy_n  = 1'b1;
                     done_n  = 1'b0;
                  end
               end else if (ev_s[0]) begin
                  a_n     = bus.ui_in;
                  done_n  = 1'b0;
                  state_n = ST_IDLE;
               end else if (ev_s[1]) begin
                  b_n     = bus.ui_in;
                  done_n  = 1'b0;
                  state_n = ST_IDLE;
               end else begin
                  state_n = state_r;
               end
            end
            ST_RUN: begin
               // Loads and start are deliberately ignored while iterating.
               acc_n      = logic_unit(acc_r, b_work_r);
               last_and_n = acc_r[7];
               if (ROT_B != 0) begin
                  b_work_n = rotl1(b_work_r);
               end else begin
                  b_work_n = b_work_r;
               end
               cnt_n = cnt_r - CNT_ONE;
               if (cnt_r == CNT_ONE) begin
                  state_n = ST_DONE;
                  busy_n  = 1'b0;
                  done_n  = 1'b1;
               end else begin
                  state_n = ST_RUN;
               end
            end
            default: begin
               state_n = ST_IDLE;
               busy_n  = 1'b0;
               done_n  = 1'b0;
            end
         endcase
      end
   end

   // State, datapath and edge-detect registers; prev_ctl resets high so held strobes are not edges.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r    <= ST_IDLE;
         a_r        <= 8'h00;
         b_r        <= 8'h00;
         b_work_r   <= 8'h00;
         acc_r      <= 8'h00;
         cnt_r      <= CNT_ZERO;
         busy_r     <= 1'b0;
         done_r     <= 1'b0;
         last_and_r <= 1'b0;
         prev_ctl_r <= 4'hF;
      end else begin
         state_r    <= state_n;
         a_r        <= a_n;
         b_r        <= b_n;
         b_work_r   <= b_work_n;
         acc_r      <= acc_n;
         cnt_r      <= cnt_n;
         busy_r     <= busy_n;
         done_r     <= done_n;
         last_and_r <= last_and_n;
         prev_ctl_r <= bus.uio_in[3:0];
      end
   end

   assign bus.uo_out  = acc_r;
   assign bus.uio_out = {1'b0, last_and_r, done_r, busy_r, 4'b0000};
   assign bus.uio_oe  = 8'hF0;

endmodule
